ram_access_arbiter: RTL and testbench

//  Shares the single-port 4-bit nibble RAM (data RAM + display memory) between the CPU core,
//  the LCD segment scanout and the savestate engine. The CPU owns the port whenever it requests,
//  so instruction cycle counts (5/7/12 clocks) never stretch. Scanout and savestate are

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/ram_access_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_access_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the nibble RAM access arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_VID  = 2'd2,
    REQ_SS   = 2'd3
  } req_tag_t;

  localparam int STARVE_W = 8;

  // Saturating increment for the starve wait counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val);
    logic [STARVE_W-1:0] res;
    if (val == {STARVE_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(STARVE_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = scanout, bit 1 = savestate.
// The preference bit flips to the loser each time a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_prio_ss;

  // Preference register: after a win, the other requester is favoured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_ss <= 1'b0;
    end else if (advance) begin
      r_prio_ss <= grant[0];
    end else begin
      r_prio_ss <= r_prio_ss;
    end
  end

  // Grant decode: a lone requester always wins, contention goes by preference.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_prio_ss ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port nibble RAM between CPU (absolute priority), LCD scanout
// and savestate engine (round-robin in CPU-idle cycles).
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wdata,
  output logic [3:0]        cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [3:0]        vid_rdata,
  input  logic              ss_req,
  input  logic              ss_we,
  input  logic [ADDR_W-1:0] ss_addr,
  input  logic [3:0]        ss_wdata,
  output logic              ss_ack,
  output logic              ss_rvalid,
  output logic [3:0]        ss_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata,
  output logic              starve
);

  logic [1:0]          w_sec_req;
  logic [1:0]          w_sec_grant;
  req_tag_t            w_tag_next;
  req_tag_t            r_tag;
  logic [3:0]          r_cpu_rdata;
  logic [3:0]          r_vid_rdata;
  logic [3:0]          r_ss_rdata;
  logic [STARVE_W-1:0] r_wait_cnt;
  logic [STARVE_W-1:0] w_wait_next;
  logic                w_sec_pending;
  logic                w_sec_acked;
  logic                r_starve;

  // Secondaries only compete when the CPU leaves the port free.
  assign w_sec_req = {ss_req, vid_req} & {2{~cpu_req}};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_sec_req),
    .advance (|w_sec_grant),
    .grant   (w_sec_grant)
  );

  assign vid_ack = w_sec_grant[0];
  assign ss_ack  = w_sec_grant[1];

  // RAM port mux and read tag for the access issued this cycle.
  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = {ADDR_W{1'b0}};
    ram_wdata  = 4'h0;
    w_tag_next = REQ_NONE;
    if (cpu_req) begin
      ram_en     = 1'b1;
      ram_we     = cpu_we;
      ram_addr   = cpu_addr;
      ram_wdata  = cpu_wdata;
      w_tag_next = cpu_we ? REQ_NONE : REQ_CPU;
    end else if (w_sec_grant[0]) begin
      ram_en     = 1'b1;
      ram_addr   = vid_addr;
      w_tag_next = REQ_VID;
    end else if (w_sec_grant[1]) begin
      ram_en     = 1'b1;
      ram_we     = ss_we;
      ram_addr   = ss_addr;
      ram_wdata  = ss_wdata;
      w_tag_next = ss_we ? REQ_NONE : REQ_SS;
    end else begin
      w_tag_next = REQ_NONE;
    end
  end

  // One-deep in-flight tag; reset drops any outstanding response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag <= REQ_NONE;
    end else begin
      r_tag <= w_tag_next;
    end
  end

  // Hold registers keep each port's last read nibble between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata <= 4'h0;
      r_vid_rdata <= 4'h0;
      r_ss_rdata  <= 4'h0;
    end else begin
      case (r_tag)
        REQ_CPU: r_cpu_rdata <= ram_rdata;
        REQ_VID: r_vid_rdata <= ram_rdata;
        REQ_SS:  r_ss_rdata  <= ram_rdata;
        default: begin
          r_cpu_rdata <= r_cpu_rdata;
          r_vid_rdata <= r_vid_rdata;
          r_ss_rdata  <= r_ss_rdata;
        end
      endcase
    end
  end

  assign cpu_rdata  = (r_tag == REQ_CPU) ? ram_rdata : r_cpu_rdata;
  assign vid_rdata  = (r_tag == REQ_VID) ? ram_rdata : r_vid_rdata;
  assign ss_rdata   = (r_tag == REQ_SS)  ? ram_rdata : r_ss_rdata;
  assign vid_rvalid = (r_tag == REQ_VID);
  assign ss_rvalid  = (r_tag == REQ_SS);

  assign w_sec_pending = (vid_req & ~vid_ack) | (ss_req & ~ss_ack);
  assign w_sec_acked   = vid_ack | ss_ack;

  // Wait counter: any secondary ack restarts the count.
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_sec_acked) begin
      w_wait_next = {STARVE_W{1'b0}};
    end else if (w_sec_pending) begin
      w_wait_next = sat_inc(r_wait_cnt);
    end else begin
      w_wait_next = r_wait_cnt;
    end
  end

  // Counter and sticky starve flag; the flag is set the edge the count reaches the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= {STARVE_W{1'b0}};
      r_starve   <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      r_starve   <= r_starve | (w_wait_next == STARVE_W'(STARVE_LIMIT));
    end
  end

  assign starve = r_starve;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed self-checking bench for ram_access_arbiter with a write-first sync RAM model.
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_wdata, cpu_rdata;
  logic        vid_req, vid_ack, vid_rvalid;
  logic [11:0] vid_addr;
  logic [3:0]  vid_rdata;
  logic        ss_req, ss_we, ss_ack, ss_rvalid;
  logic [11:0] ss_addr;
  logic [3:0]  ss_wdata, ss_rdata;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata = 4'h0;
  logic        starve;
  logic [3:0]  mem [0:4095];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(12), .STARVE_LIMIT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_ack(ss_ack), .ss_rvalid(ss_rvalid), .ss_rdata(ss_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .starve(starve)
  );

  // Write-first synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 4'h0;
    vid_req = 1'b0; vid_addr = 12'h000;
    ss_req = 1'b0; ss_we = 1'b0; ss_addr = 12'h000; ss_wdata = 4'h0;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    all_idle();
    #2;
    total_cnt++;
    if ({vid_ack, ss_ack, vid_rvalid, ss_rvalid} !== 4'b0000) $display("FAIL reset_handshake: got %b expected 0000", {vid_ack, ss_ack, vid_rvalid, ss_rvalid});
    else pass_cnt++;
    total_cnt++;
    if ({ram_en, ram_we, starve} !== 3'b000) $display("FAIL reset_ram_starve: got %b expected 000", {ram_en, ram_we, starve});
    else pass_cnt++;
    total_cnt++;
    if ({cpu_rdata, vid_rdata, ss_rdata} !== 12'h000) $display("FAIL reset_rdata: got %h expected 000", {cpu_rdata, vid_rdata, ss_rdata});
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_hs [5];
    exp_hs = '{4'b1000, 4'b0110, 4'b1001, 4'b0110, 4'b0001};
    cpu_write(12'hE00, 4'h3);
    cpu_write(12'h020, 4'h5);
    vid_req = 1'b1; vid_addr = 12'hE00;
    ss_req = 1'b1; ss_we = 1'b0; ss_addr = 12'h020;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        vid_req = 1'b0; ss_req = 1'b0;
      end
      @(negedge clk);
      total_cnt++;
      if ({vid_ack, ss_ack, vid_rvalid, ss_rvalid} !== exp_hs[i]) $display("FAIL rr_cycle%0d: got %b expected %b", i, {vid_ack, ss_ack, vid_rvalid, ss_rvalid}, exp_hs[i]);
      else pass_cnt++;
      if (vid_rvalid) begin
        total_cnt++;
        if (vid_rdata !== 4'h3) $display("FAIL rr_vid_rdata%0d: got %h expected 3", i, vid_rdata);
        else pass_cnt++;
      end
      if (ss_rvalid) begin
        total_cnt++;
        if (ss_rdata !== 4'h5) $display("FAIL rr_ss_rdata%0d: got %h expected 5", i, ss_rdata);
        else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_cpu_priority();
    vid_req = 1'b1; vid_addr = 12'hE00;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 4'h7;
    @(negedge clk);
    total_cnt++;
    if ({vid_ack, ram_we} !== 2'b01) $display("FAIL cpu_write_prio: got ack/we %b expected 01", {vid_ack, ram_we});
    else pass_cnt++;
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ram_addr, ram_we, vid_ack} !== {12'h010, 2'b00}) $display("FAIL cpu_read_issue: got addr %h we %b ack %b expected 010 0 0", ram_addr, ram_we, vid_ack);
    else pass_cnt++;
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cpu_rdata !== 4'h7) $display("FAIL cpu_rdata: got %h expected 7", cpu_rdata);
    else pass_cnt++;
    total_cnt++;
    if (vid_ack !== 1'b1) $display("FAIL vid_ack_after_cpu: got %b expected 1", vid_ack);
    else pass_cnt++;
    next_cycle();
    vid_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({vid_rvalid, vid_rdata} !== 5'h13) $display("FAIL vid_resp: got %h expected 13", {vid_rvalid, vid_rdata});
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_ss_rw();
    ss_req = 1'b1; ss_we = 1'b1; ss_addr = 12'h030; ss_wdata = 4'hA;
    @(negedge clk);
    total_cnt++;
    if ({ss_ack, ram_we, ram_wdata} !== 6'h3A) $display("FAIL ss_write_issue: got %h expected 3a", {ss_ack, ram_we, ram_wdata});
    else pass_cnt++;
    next_cycle();
    ss_we = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ss_ack, ss_rvalid} !== 2'b10) $display("FAIL ss_write_no_rvalid: got %b expected 10", {ss_ack, ss_rvalid});
    else pass_cnt++;
    next_cycle();
    ss_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({ss_rvalid, ss_rdata} !== 5'h1A) $display("FAIL ss_raw_data: got %h expected 1a", {ss_rvalid, ss_rdata});
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_starve();
    int acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000;
    vid_req = 1'b1; vid_addr = 12'hE00;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (vid_ack) acks++;
      if (i == 64) begin
        total_cnt++;
        if (starve !== 1'b0) $display("FAIL starve_early: got %b expected 0", starve);
        else pass_cnt++;
      end
      if (i == 65) begin
        total_cnt++;
        if (starve !== 1'b1) $display("FAIL starve_set: got %b expected 1", starve);
        else pass_cnt++;
      end
      next_cycle();
    end
    total_cnt++;
    if (acks !== 0) $display("FAIL starve_no_ack: got %0d acks expected 0", acks);
    else pass_cnt++;
    cpu_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({vid_ack, starve} !== 2'b11) $display("FAIL starve_ack: got %b expected 11", {vid_ack, starve});
    else pass_cnt++;
    next_cycle();
    vid_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({vid_rvalid, starve} !== 2'b11) $display("FAIL starve_sticky: got %b expected 11", {vid_rvalid, starve});
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    vid_req = 1'b1; vid_addr = 12'hE00;
    @(negedge clk);
    total_cnt++;
    if (vid_ack !== 1'b1) $display("FAIL mid_pre_ack: got %b expected 1", vid_ack);
    else pass_cnt++;
    next_cycle();
    reset_n = 1'b0;
    all_idle();
    #1;
    total_cnt++;
    if ({vid_rvalid, ss_rvalid, vid_ack, ss_ack, ram_en, ram_we, starve} !== 7'b0) $display("FAIL mid_reset_ctrl: got %b expected 0000000", {vid_rvalid, ss_rvalid, vid_ack, ss_ack, ram_en, ram_we, starve});
    else pass_cnt++;
    total_cnt++;
    if ({cpu_rdata, vid_rdata, ss_rdata} !== 12'h000) $display("FAIL mid_reset_rdata: got %h expected 000", {cpu_rdata, vid_rdata, ss_rdata});
    else pass_cnt++;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (vid_rvalid !== 1'b0) $display("FAIL mid_dropped_rvalid: got %b expected 0", vid_rvalid);
    else pass_cnt++;
    next_cycle();
    vid_req = 1'b1; vid_addr = 12'hE00;
    ss_req = 1'b1; ss_we = 1'b0; ss_addr = 12'h020;
    @(negedge clk);
    total_cnt++;
    if ({vid_ack, ss_ack} !== 2'b10) $display("FAIL mid_rr_vid_first: got %b expected 10", {vid_ack, ss_ack});
    else pass_cnt++;
    next_cycle();
    all_idle();
    next_cycle();
  endtask

  task automatic test_rlc();
    logic [6:0] exp_ack;
    exp_ack = 7'b1001110;
    cpu_write(12'h040, 4'h9);
    ss_req = 1'b1; ss_we = 1'b0; ss_addr = 12'h050;
    for (int c = 0; c < 7; c++) begin
      cpu_req = (c == 0) || (c == 4) || (c == 5);
      cpu_we = (c == 4);
      cpu_addr = 12'h040;
      cpu_wdata = 4'h2;
      @(negedge clk);
      total_cnt++;
      if (ss_ack !== exp_ack[c]) $display("FAIL rlc_ss_ack%0d: got %b expected %b", c, ss_ack, exp_ack[c]);
      else pass_cnt++;
      if (c == 0) begin
        total_cnt++;
        if (ram_addr !== 12'h040) $display("FAIL rlc_read_addr: got %h expected 040", ram_addr);
        else pass_cnt++;
      end
      if (c == 1) begin
        total_cnt++;
        if (cpu_rdata !== 4'h9) $display("FAIL rlc_read_data: got %h expected 9", cpu_rdata);
        else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++;
        if ({ram_we, ram_wdata} !== 5'h12) $display("FAIL rlc_write: got %h expected 12", {ram_we, ram_wdata});
        else pass_cnt++;
      end
      if (c == 6) begin
        total_cnt++;
        if (cpu_rdata !== 4'h2) $display("FAIL rlc_result: got %h expected 2", cpu_rdata);
        else pass_cnt++;
      end
      next_cycle();
    end
    all_idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_cpu_priority();
    test_ss_rw();
    test_starve();
    test_reset_mid();
    test_rlc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
